// File: rtl/freq_gate_ctrl.sv
// -----------------------------------------------------------------------------
// freq_gate_ctrl
//
// Measurement-window controller for the frequency meter. It sequences one
// measurement as IDLE -> CLEAR -> GATE -> SETTLE -> LATCH -> IDLE. It drives
// the clear and gate inputs of the downstream 6-digit BCD event counter and
// latches that counter's result for display.
//
// Parameters
//   GATE_CYCLES   : clocks ENA is held high (gate window), >= 1
//   CLR_CYCLES    : clocks CNT_CLR is held high before each gate, >= 1
//   SETTLE_CYCLES : clocks between ENA falling and sampling Q_IN, >= 1
//
// Ports
//   CLK       in   reference clock, everything on posedge
//   RST       in   synchronous reset, active-high
//   RUN       in   measurement enable, looked at only while IDLE
//   Q_IN      in   24-bit BCD count from the counter (digit 0 in [3:0])
//   ENA       out  gate to counter
//   CNT_CLR   out  clear to counter
//   DOUT      out  last latched BCD reading
//   VALID     out  one-cycle pulse, DOUT updated this cycle
//   ERR       out  last latched reading had a nibble > 9
//   BUSY      out  high in every state except IDLE
//   state_dbg out  current FSM state, for observation only
//
// Handshake: VALID is a single-cycle strobe with no ready/backpressure. A
// consumer must capture DOUT/ERR in the cycle VALID is high. After that
// cycle, DOUT/ERR stay stable until the next VALID.
// -----------------------------------------------------------------------------
module freq_gate_ctrl #(
    parameter int GATE_CYCLES   = 1000,
    parameter int CLR_CYCLES    = 2,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        RUN,
    input  logic [23:0] Q_IN,
    output logic        ENA,
    output logic        CNT_CLR,
    output logic [23:0] DOUT,
    output logic        VALID,
    output logic        ERR,
    output logic        BUSY,
    output logic [2:0]  state_dbg
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_GATE   = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_LATCH  = 3'd4;

    // The counter is loaded with N-1 on state entry and counts down to 0.
    // It therefore only has to hold values up to max(N)-1.
    localparam int MAX_A   = (GATE_CYCLES > CLR_CYCLES) ? GATE_CYCLES : CLR_CYCLES;
    localparam int MAX_CYC = (MAX_A > SETTLE_CYCLES) ? MAX_A : SETTLE_CYCLES;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CW-1:0] CLR_LOAD    = CW'(CLR_CYCLES - 1);
    localparam logic [CW-1:0] GATE_LOAD   = CW'(GATE_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

    logic [2:0]    state, state_n;
    logic [CW-1:0] cnt, cnt_n;

    function automatic logic has_non_bcd(input logic [23:0] q);
        logic bad;
        bad = 1'b0;
        for (int d = 0; d < 6; d++) begin
            if (q[4*d +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            S_IDLE: begin
                if (RUN) begin
                    state_n = S_CLEAR;
                    cnt_n   = CLR_LOAD;
                end
            end
            S_CLEAR: begin
                if (cnt == '0) begin
                    state_n = S_GATE;
                    cnt_n   = GATE_LOAD;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            S_GATE: begin
                if (cnt == '0) begin
                    state_n = S_SETTLE;
                    cnt_n   = SETTLE_LOAD;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            S_SETTLE: begin
                if (cnt == '0) begin
                    state_n = S_LATCH;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            S_LATCH: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Outputs decode the next state, so they are registered. They are valid
    // in the same cycle as the state they belong to.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_IDLE;
            cnt     <= '0;
            ENA     <= 1'b0;
            CNT_CLR <= 1'b0;
            DOUT    <= 24'h000000;
            VALID   <= 1'b0;
            ERR     <= 1'b0;
            BUSY    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            ENA     <= (state_n == S_GATE);
            CNT_CLR <= (state_n == S_CLEAR);
            BUSY    <= (state_n != S_IDLE);
            VALID   <= (state == S_LATCH);
            if (state == S_LATCH) begin
                DOUT <= Q_IN;
                ERR  <= has_non_bcd(Q_IN);
            end
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// -----------------------------------------------------------------------------
// tb_freq_gate_ctrl
//
// Directed bench for freq_gate_ctrl with GATE=10, CLR=2, SETTLE=3. One
// measurement is therefore 17 cycles from the RUN-sampling edge to the
// VALID cycle. Inputs change on the falling edge, and outputs are checked
// on the falling edge.
// -----------------------------------------------------------------------------
module tb_freq_gate_ctrl;

    localparam int G = 10;
    localparam int C = 2;
    localparam int S = 3;
    localparam int PERIOD = C + G + S + 2;

    logic        clk;
    logic        rst;
    logic        run;
    logic [23:0] q_in;
    logic        ena;
    logic        cnt_clr;
    logic [23:0] dout;
    logic        valid;
    logic        err;
    logic        busy;
    logic [2:0]  state_dbg;

    int total = 0;
    int bad   = 0;
    logic [23:0] exp_dout = 24'h000000;
    logic        exp_err  = 1'b0;

    freq_gate_ctrl #(
        .GATE_CYCLES  (G),
        .CLR_CYCLES   (C),
        .SETTLE_CYCLES(S)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .RUN      (run),
        .Q_IN     (q_in),
        .ENA      (ena),
        .CNT_CLR  (cnt_clr),
        .DOUT     (dout),
        .VALID    (valid),
        .ERR      (err),
        .BUSY     (busy),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".ena"},   {23'd0, ena},     24'd0);
        chk({tag, ".clr"},   {23'd0, cnt_clr}, 24'd0);
        chk({tag, ".busy"},  {23'd0, busy},    24'd0);
        chk({tag, ".valid"}, {23'd0, valid},   24'd0);
        chk({tag, ".dout"},  dout,             exp_dout);
        chk({tag, ".err"},   {23'd0, err},     {23'd0, exp_err});
    endtask

    // Entry: just after the edge that sampled RUN=1 in IDLE, so the current
    // cycle is i=1. Exit: in the VALID cycle (i=PERIOD), before any further
    // edge. Q_IN carries junk except in the LATCH cycle, so any early or late
    // sampling shows up as a wrong DOUT. drop_at>0 releases RUN at that
    // cycle.
    task automatic measure(input string tag, input logic [23:0] q,
                           input logic q_err, input int drop_at);
        for (int i = 1; i <= PERIOD; i++) begin
            if (i == drop_at) run = 1'b0;
            q_in = (i == PERIOD - 1) ? q : 24'($urandom_range(0, 24'hFFFFFF));
            chk($sformatf("%s.ena[%0d]", tag, i), {23'd0, ena},
                {23'd0, (i >= C + 1 && i <= C + G)});
            chk($sformatf("%s.clr[%0d]", tag, i), {23'd0, cnt_clr},
                {23'd0, (i >= 1 && i <= C)});
            chk($sformatf("%s.busy[%0d]", tag, i), {23'd0, busy},
                {23'd0, (i < PERIOD)});
            chk($sformatf("%s.valid[%0d]", tag, i), {23'd0, valid},
                {23'd0, (i == PERIOD)});
            chk($sformatf("%s.overlap[%0d]", tag, i), {23'd0, ena & cnt_clr}, 24'd0);
            if (i == PERIOD) begin
                exp_dout = q;
                exp_err  = q_err;
            end
            chk($sformatf("%s.dout[%0d]", tag, i), dout, exp_dout);
            chk($sformatf("%s.err[%0d]", tag, i), {23'd0, err}, {23'd0, exp_err});
            if (i < PERIOD) step();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst  = 1'b1;
        run  = 1'b1;
        q_in = 24'h123456;
        @(negedge clk);
        step();
        step();
        chk_idle("reset");
        chk("reset.state", {21'd0, state_dbg}, 24'd0);
        rst = 1'b0;
        run = 1'b0;
        step();
        chk_idle("post_reset");

        // Reset and RUN on the same edge: reset wins, RUN is resampled next.
        rst = 1'b1;
        run = 1'b1;
        step();
        chk_idle("rst_run");
        rst = 1'b0;
        step();
        run = 1'b0;
        measure("rst_then_run", 24'h000011, 1'b0, 0);
        step();

        // Single shot: one-cycle RUN pulse.
        run = 1'b1;
        step();
        run = 1'b0;
        measure("single", 24'h000042, 1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk_idle("single_after");
        end

        // Continuous: RUN held high, back-to-back measurements.
        run = 1'b1;
        step();
        measure("cont0", 24'h000100, 1'b0, 0);
        step();
        measure("cont1", 24'h999999, 1'b0, 0);
        step();
        measure("nonbcd", 24'h0000A0, 1'b1, 0);
        step();
        measure("bcd_again", 24'h000090, 1'b0, 0);
        run = 1'b0;
        step();
        chk_idle("cont_stop");

        // Abort: reset in the 5th gate cycle.
        run = 1'b1;
        step();
        run = 1'b0;
        for (int i = 1; i < C + 5; i++) step();
        chk("abort.ena_before", {23'd0, ena}, 24'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_dout = 24'h000000;
        exp_err  = 1'b0;
        for (int i = 0; i < PERIOD + 3; i++) begin
            chk_idle("abort");
            step();
        end
        run = 1'b1;
        step();
        run = 1'b0;
        measure("restart", 24'h000777, 1'b0, 0);

        // RUN drop during the gate: the measurement completes, and then the
        // block stays idle.
        step();
        run = 1'b1;
        step();
        measure("run_drop", 24'h054321, 1'b0, C + 4);
        for (int i = 0; i < PERIOD + 2; i++) begin
            step();
            chk_idle("run_drop_after");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/freq_gate_ctrl.md
# freq_gate_ctrl

Measurement-window controller for the frequency meter: it generates the gate and clear signals for the 6-digit BCD event counter and latches the counter's result for display. It runs on the system reference clock and sits directly upstream of the counter, driving its ENA and CLR inputs. It also sits downstream of the counter, sampling its 24-bit BCD Q output once per measurement and presenting a stable, validated reading.

## Interface
- GATE_CYCLES, 1000: CLK cycles ENA is held high (gate window); ≥1
- CLR_CYCLES, 2: CLK cycles CNT_CLR is held high before each gate; ≥1
- SETTLE_CYCLES, 3: CLK cycles between ENA falling and sampling Q_IN; ≥1; covers F_IN-domain settling
- CLK  in  1  reference clock, all logic on posedge
- RST  in  1  synchronous reset, active-high
- RUN  in  1  measurement enable; sampled only in IDLE
- Q_IN  in  24  BCD count from counter, digit 0 in [3:0] … digit 5 in [23:20]
- ENA  out  1  gate to counter
- CNT_CLR  out  1  clear to counter
- DOUT  out  24  last latched BCD reading
- VALID  out  1  one-cycle pulse: DOUT just updated
- ERR  out  1  last latched reading contained a non-BCD nibble (>9)
- BUSY  out  1  high in every state except IDLE

## Operation
- All outputs are registered. States: IDLE, CLEAR, GATE, SETTLE, LATCH. One down-counter loaded on each state entry.
- IDLE: ENA=0, CNT_CLR=0. If RUN=1, go to CLEAR. Otherwise stay.
- CLEAR: CNT_CLR=1 for exactly CLR_CYCLES cycles, ENA=0. Then go to GATE.
- GATE: ENA=1 for exactly GATE_CYCLES cycles, CNT_CLR=0. Then go to SETTLE.
- SETTLE: ENA=0, CNT_CLR=0 for exactly SETTLE_CYCLES cycles. Then go to LATCH.
- LATCH lasts 1 cycle. At its closing edge:
  - DOUT<=Q_IN
  - ERR<=1 if any nibble of Q_IN >9, else 0
  - VALID<=1
  - go to IDLE
- VALID is high for exactly the first IDLE cycle, then 0.
- DOUT and ERR hold their values between latches. Q_IN is ignored outside the LATCH closing edge.
- RUN is not sampled outside IDLE. Deasserting RUN mid-measurement lets the current measurement complete and latch. The block then stays in IDLE.
- ENA and CNT_CLR are never high in the same cycle.
- The down-counter is wide enough for max(GATE_CYCLES, CLR_CYCLES, SETTLE_CYCLES). No wrap inside a state.

## Timing
- Reset: at any posedge with RST=1, all of the following take effect, overriding all else:
  - state=IDLE, ENA=0, CNT_CLR=0, DOUT=24'h000000, VALID=0, ERR=0, BUSY=0
  - counter=0
- Reset mid-GATE aborts the measurement. ENA is 0 from the next cycle and no VALID is produced.
- If RUN=1 is sampled at edge k in IDLE:
  - CNT_CLR and BUSY are high in cycles k+1 … k+CLR_CYCLES.
  - ENA is high in cycles k+CLR_CYCLES+1 … k+CLR_CYCLES+GATE_CYCLES.
  - LATCH occupies cycle k+C+G+S+1.
  - VALID is high in cycle k+C+G+S+2, with DOUT updated in that same cycle.
- With RUN held high, IDLE lasts 1 cycle. Measurement period = CLR_CYCLES+GATE_CYCLES+SETTLE_CYCLES+2 cycles.
- VALID coincides with BUSY=0. If RUN=1 in that cycle, BUSY rises again the next cycle.
- RST and RUN asserted on the same edge: RST wins; IDLE next cycle, and RUN is resampled the following edge.

## Test plan
All scenarios use GATE_CYCLES=10, CLR_CYCLES=2, SETTLE_CYCLES=3.
- Reset: assert RST with Q_IN=24'h123456 and RUN=1 for 2 cycles, then RUN=0 → all outputs 0, BUSY=0, DOUT=24'h000000.
- Single shot: RUN=1 for one cycle at edge k, Q_IN=24'h000042 → CNT_CLR high cycles k+1..k+2; ENA high k+3..k+12; VALID high only at k+17; DOUT=24'h000042, ERR=0.
- Continuous: RUN held high, Q_IN stepped to 24'h000100 then 24'h999999 → VALID pulses every 17 cycles; DOUT follows each latched value; ENA/CNT_CLR never overlap.
- Non-BCD: Q_IN=24'h0000A0 at latch → DOUT=24'h0000A0, ERR=1. Next latch with 24'h000090 → ERR=0.
- Abort: RST at 5th ENA cycle → ENA=0 next cycle, no VALID, DOUT=24'h000000. RUN=1 afterwards restarts with the full CLEAR→GATE sequence.
- RUN drop: RUN 1→0 during GATE → measurement completes, one VALID pulse, then IDLE with BUSY=0 and no further CNT_CLR.
